endstop_ctrl: RTL and testbench

Sequences a bank of N `debounce` instances: captures their change strobes, applies per-channel enable and polarity, and raises a sticky motion abort. It shares one host event channel among the N endstops by round-robin, then issues each debouncer's `unlock` once its event has been accepted. It sits between the debounce bank and the motion/host register block.

---
 rtl/endstop_pkg.sv | 23 ++
 rtl/endstop_ctrl_if.sv | 29 ++
 rtl/rr_pick.sv | 36 +++
 rtl/endstop_ctrl.sv | 139 +++++++++++++
 tb/tb_endstop_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/endstop_pkg.sv
// rtl/endstop_pkg.sv - shared types and constants for the endstop controller
// Purpose: FSM state encoding, default channel count and index-width helper.
// Ports: none (package).
package endstop_pkg;

  localparam int N_DEFAULT = 8;

  // Smallest width able to index n channels (at least 1 bit).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_UNLOCK,
    S_SETTLE
  } state_t;

endpackage

// File: rtl/endstop_ctrl_if.sv
// rtl/endstop_ctrl_if.sv - host event channel between endstop_ctrl and the register block
// Purpose: groups the event handshake.
// Ports: evt_valid/evt_channel/evt_level from the controller (master), evt_ready from the host (slave).
interface endstop_ctrl_if
  import endstop_pkg::*;
#(
  parameter int IW = idx_width(N_DEFAULT)
) ();

  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_channel;
  logic          evt_level;

  modport master (
    output evt_valid,
    output evt_channel,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_channel,
    input  evt_level,
    output evt_ready
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set search
// Purpose: returns the first set request at or after ptr, wrapping N-1 to 0.
// Ports: req[N] requests, ptr start index, grant_idx chosen index, any request present.
module rr_pick
  import endstop_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down to zero so the nearest hit is the last write.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (req[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/endstop_ctrl.sv
// rtl/endstop_ctrl.sv - debounce-bank sequencer with abort latch and round-robin event channel
// Purpose: captures debouncer strobes, reports them one at a time to the host, unlocks each
//          debouncer after its event is accepted (or discarded when disabled), and latches abort.
// Ports: clk, reset (async, active-high); db_signal/db_stb/db_locked in, db_unlock out (per channel);
//        enable_mask/polarity/abort_mask config; abort_clear in; abort/abort_src/active out;
//        evt (master) host event handshake.
module endstop_ctrl
  import endstop_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   db_signal,
  input  logic [N-1:0]   db_stb,
  input  logic [N-1:0]   db_locked,
  output logic [N-1:0]   db_unlock,
  input  logic [N-1:0]   enable_mask,
  input  logic [N-1:0]   polarity,
  input  logic [N-1:0]   abort_mask,
  input  logic           abort_clear,
  output logic           abort,
  output logic [N-1:0]   abort_src,
  output logic [N-1:0]   active,
  endstop_ctrl_if.master evt
);

  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  cap_level_q, cap_level_d;
  logic          abort_q, abort_d;
  logic [N-1:0]  abort_src_q, abort_src_d;
  logic [N-1:0]  active_q, active_d;

  logic [N-1:0]  level;
  logic [N-1:0]  trig;
  logic [N-1:0]  cur_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          present;

  assign level      = db_signal ^ polarity;
  assign trig       = db_stb & enable_mask & abort_mask & level;
  assign cur_onehot = LSB_ONE << cur_q;
  assign present    = (state_q == S_PRESENT);

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req       (pending_q),
    .ptr       (rr_q),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    active_d = enable_mask & level;

    // A new trigger beats a simultaneous clear so no abort cause is ever lost.
    if (abort_clear) begin
      abort_d     = |trig;
      abort_src_d = trig;
    end else begin
      abort_d     = abort_q | (|trig);
      abort_src_d = abort_src_q | trig;
    end

    cap_level_d = (cap_level_q & ~db_stb) | (db_stb & level);
    pending_d   = pending_q | db_stb;

    state_d = state_q;
    cur_d   = cur_q;
    rr_d    = rr_q;

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          cur_d   = pick_idx;
          // Disabled channels skip the host but are still unlocked.
          state_d = enable_mask[pick_idx] ? S_PRESENT : S_UNLOCK;
        end
      end
      S_PRESENT: begin
        if (evt.evt_ready) state_d = S_UNLOCK;
      end
      S_UNLOCK: begin
        pending_d = (pending_q & ~cur_onehot) | db_stb;
        rr_d      = (cur_q == IW'(N - 1)) ? '0 : cur_q + 1'b1;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rr_q        <= '0;
      pending_q   <= '0;
      cap_level_q <= '0;
      abort_q     <= 1'b0;
      abort_src_q <= '0;
      active_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rr_q        <= rr_d;
      pending_q   <= pending_d;
      cap_level_q <= cap_level_d;
      abort_q     <= abort_d;
      abort_src_q <= abort_src_d;
      active_q    <= active_d;
    end
  end

  assign db_unlock       = (state_q == S_UNLOCK) ? cur_onehot : '0;
  assign evt.evt_valid   = present;
  assign evt.evt_channel = cur_q;
  assign evt.evt_level   = present & cap_level_q[cur_q];
  assign abort           = abort_q;
  assign abort_src       = abort_src_q;
  assign active          = active_q;

  // A debouncer still locked one cycle after its unlock has broken the handshake;
  // the scheduler does not wait for it.
  settle_unlocked_chk: assert property (
    @(posedge clk) disable iff (reset) (state_q == S_SETTLE) |-> !db_locked[cur_q]
  );

endmodule

// File: tb/tb_endstop_ctrl.sv
// tb/tb_endstop_ctrl.sv - scoreboard testbench for endstop_ctrl
module tb_endstop_ctrl;
  import endstop_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] db_signal, db_stb, db_unlock;
  logic [N-1:0] db_locked = '0;
  logic [N-1:0] enable_mask, polarity, abort_mask, abort_src, active;
  logic         abort_clear, abort;

  endstop_ctrl_if #(.IW(IW)) evt ();

  endstop_ctrl #(.N(N), .IW(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .db_signal   (db_signal),
    .db_stb      (db_stb),
    .db_locked   (db_locked),
    .db_unlock   (db_unlock),
    .enable_mask (enable_mask),
    .polarity    (polarity),
    .abort_mask  (abort_mask),
    .abort_clear (abort_clear),
    .abort       (abort),
    .abort_src   (abort_src),
    .active      (active),
    .evt         (evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit lvl;
  } evt_t;

  int n_cmp = 0;
  int n_bad = 0;

  evt_t exp_evt[$];
  int   exp_unl[$];
  int   rr = 0;
  logic         exp_abort = 1'b0;
  logic [N-1:0] exp_abort_src = '0;
  logic [N-1:0] exp_active = '0;
  logic mon_en = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_sig = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Debouncer stand-in: locks on its strobe, releases on unlock.
  always @(negedge clk) begin
    if (reset) db_locked = '0;
    else       db_locked = (db_locked | db_stb) & ~db_unlock;
  end

  // Monitor: compares every presented event/unlock against the scoreboard queues.
  logic          prev_hold = 1'b0;
  logic [IW-1:0] prev_ch;
  logic          prev_lvl;
  evt_t          m_e;
  int            m_u;

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      prev_hold = 1'b0;
    end else begin
      check("abort", abort, exp_abort);
      check("abort_src", abort_src, exp_abort_src);
      check("active", active, exp_active);
      if (prev_hold) begin
        check("hold_valid", evt.evt_valid, 1);
        check("hold_channel", evt.evt_channel, prev_ch);
        check("hold_level", evt.evt_level, prev_lvl);
      end
      prev_hold = evt.evt_valid && !evt.evt_ready;
      prev_ch   = evt.evt_channel;
      prev_lvl  = evt.evt_level;
      if (evt.evt_valid && evt.evt_ready) begin
        if (exp_evt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: got channel %0d expected none", evt.evt_channel);
        end else begin
          m_e = exp_evt.pop_front();
          check("evt_channel", evt.evt_channel, m_e.ch);
          check("evt_level", evt.evt_level, m_e.lvl);
        end
      end
      if (db_unlock != '0) begin
        if (exp_unl.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_unlock: got %0h expected none", db_unlock);
        end else begin
          m_u = exp_unl.pop_front();
          check("db_unlock", db_unlock, 32'(1) << m_u);
        end
      end
    end
  end

  // One clock: predict the registered outputs from the inputs in effect, then advance.
  task automatic step();
    logic [N-1:0] lv, trig, n_src, n_act;
    logic n_abort;
    lv   = db_signal ^ polarity;
    trig = db_stb & enable_mask & abort_mask & lv;
    if (abort_clear) begin
      n_src = trig; n_abort = |trig;
    end else begin
      n_src = exp_abort_src | trig; n_abort = exp_abort | (|trig);
    end
    n_act = enable_mask & lv;
    @(posedge clk);
    exp_abort = n_abort;
    exp_abort_src = n_src;
    exp_active = n_act;
    #1;
    db_stb = '0;
    abort_clear = 1'b0;
    if (rnd_sig) db_signal = N'($urandom);
    if (rnd_ready) evt.evt_ready = 1'($urandom_range(0, 1));
  endtask

  // Strobe a set of idle channels together; service order is a rotation starting at rr.
  task automatic burst(input logic [N-1:0] set);
    logic [N-1:0] lv;
    int last;
    lv = db_signal ^ polarity;
    last = -1;
    db_stb = set;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr + k) % N;
      if (set[c]) begin
        exp_unl.push_back(c);
        if (enable_mask[c]) exp_evt.push_back('{ch: c, lvl: lv[c]});
        last = c;
      end
    end
    if (last >= 0) rr = (last + 1) % N;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_unl.size() != 0 && b < 300) begin
      if (rnd_sig && $urandom_range(0, 15) == 0) abort_clear = 1'b1;
      step();
      b++;
    end
    if (exp_unl.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d unlocks outstanding expected 0", exp_unl.size());
    end
    step(); step(); step();
    check("events_left", exp_evt.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_evt_valid"}, evt.evt_valid, 0);
    check({tag, "_evt_channel"}, evt.evt_channel, 0);
    check({tag, "_evt_level"}, evt.evt_level, 0);
    check({tag, "_db_unlock"}, db_unlock, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_abort_src"}, abort_src, 0);
    check({tag, "_active"}, active, 0);
  endtask

  int vk[$];
  int vc[$];

  initial begin
    reset = 1'b1;
    db_signal = '0; db_stb = '0; enable_mask = '0; polarity = '0; abort_mask = '0;
    abort_clear = 1'b0;
    evt.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    enable_mask = '1;
    mon_en = 1'b1;
    step();

    // Simultaneous strobes on 1, 5, 6 from rr=0 with the host always ready.
    db_signal = 8'h20;
    evt.evt_ready = 1'b1;
    burst(8'h62);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (evt.evt_valid) begin
        vk.push_back(k);
        vc.push_back(int'(evt.evt_channel));
      end
    end
    check("rr_count", vk.size(), 3);
    if (vk.size() == 3) begin
      check("rr_first_latency", vk[0], 2);
      check("rr_gap_a", vk[1] - vk[0], 4);
      check("rr_gap_b", vk[2] - vk[1], 4);
      check("rr_ch_a", vc[0], 1);
      check("rr_ch_b", vc[1], 5);
      check("rr_ch_c", vc[2], 6);
    end
    drain();

    // Single channel 3, rising, host accepts at t+5.
    evt.evt_ready = 1'b0;
    db_signal = 8'h08;
    burst(8'h08);
    step();
    check("ch3_t1_valid", evt.evt_valid, 0);
    step();
    check("ch3_t2_valid", evt.evt_valid, 1);
    check("ch3_t2_channel", evt.evt_channel, 3);
    check("ch3_t2_level", evt.evt_level, 1);
    step(); step(); step();
    check("ch3_t5_unlock", db_unlock, 0);
    evt.evt_ready = 1'b1;
    step();
    check("ch3_t6_unlock", db_unlock, 8'h08);
    evt.evt_ready = 1'b0;
    step();
    check("ch3_t7_unlock", db_unlock, 0);
    drain();

    // Backpressure on channel 2 (falling level) for 20 cycles.
    db_signal = 8'h00;
    burst(8'h04);
    step(); step();
    for (int k = 0; k < 20; k++) begin
      check("bp_unlock", db_unlock, 0);
      check("bp_channel", evt.evt_channel, 2);
      check("bp_level", evt.evt_level, 0);
      step();
    end
    evt.evt_ready = 1'b1;
    step();
    evt.evt_ready = 1'b0;
    drain();

    // Disabled channel 4: silently unlocked at t+2.
    enable_mask = 8'hEF;
    burst(8'h10);
    step();
    check("dis_t1_unlock", db_unlock, 0);
    check("dis_t1_valid", evt.evt_valid, 0);
    step();
    check("dis_t2_unlock", db_unlock, 8'h10);
    check("dis_t2_valid", evt.evt_valid, 0);
    step();
    check("dis_t3_valid", evt.evt_valid, 0);
    drain();
    enable_mask = '1;

    // Abort: channel 0 active-low, then clear, then clear racing a channel 7 trigger.
    evt.evt_ready = 1'b1;
    abort_mask = 8'h81;
    polarity = 8'h01;
    db_signal = 8'h01;
    step();
    db_signal = 8'h00;
    burst(8'h01);
    step();
    check("abort_set", abort, 1);
    check("abort_src_set", abort_src, 8'h01);
    drain();
    abort_clear = 1'b1;
    step();
    check("abort_clr", abort, 0);
    check("abort_src_clr", abort_src, 0);
    db_signal = 8'h01;
    step();
    db_signal = 8'h00;
    burst(8'h01);
    step();
    drain();
    db_signal = 8'h80;
    burst(8'h80);
    abort_clear = 1'b1;
    step();
    check("abort_race", abort, 1);
    check("abort_src_race", abort_src, 8'h80);
    drain();
    abort_clear = 1'b1;
    step();
    polarity = '0;
    abort_mask = '0;

    // Randomized bursts against the rotation model.
    rnd_sig = 1'b1;
    rnd_ready = 1'b1;
    repeat (40) begin
      logic [N-1:0] set;
      enable_mask = N'($urandom);
      polarity    = N'($urandom);
      abort_mask  = N'($urandom);
      set = N'($urandom);
      if (set == '0) set = 8'h01;
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 3) == 0) abort_clear = 1'b1;
      burst(set);
      step();
      drain();
    end
    rnd_sig = 1'b0;
    rnd_ready = 1'b0;

    // Reset while an event is being presented.
    enable_mask = '1;
    polarity = '0;
    abort_mask = '0;
    evt.evt_ready = 1'b0;
    db_signal = 8'h04;
    burst(8'h04);
    step(); step();
    check("rst_pre_valid", evt.evt_valid, 1);
    #2;
    reset = 1'b1;
    mon_en = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    exp_evt.delete();
    exp_unl.delete();
    rr = 0;
    exp_abort = 1'b0;
    exp_abort_src = '0;
    exp_active = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    evt.evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("post_rst_valid", evt.evt_valid, 0);
      check("post_rst_unlock", db_unlock, 0);
    end
    burst(8'h40);
    step();
    check("post_rst_t1_valid", evt.evt_valid, 0);
    step();
    check("post_rst_t2_valid", evt.evt_valid, 1);
    check("post_rst_t2_channel", evt.evt_channel, 6);
    drain();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
